ng_panel: RTL and testbench

Parametrised front-panel input conditioner, the next generation of the monitor-switch logic. It takes N_CH raw switch/button lines and produces clean per-channel signals for the clock/step control logic:
- a prescaler-driven sample tick;
- per-channel two-flop synchronisation and polarity correction;
- counter-based debounce;
- one-cycle rise/fall pulses;
- optional auto-repeat press pulses for held buttons.

It replaces ad-hoc per-switch flops feeding MCLK/NSTEP-style controls.

---
 rtl/ng_panel_pkg.sv | 18 +
 rtl/ng_panel_ch.sv | 128 ++++++++++++
 rtl/ng_panel.sv | 81 ++++++++
 tb/tb_ng_panel.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ng_panel_pkg.sv
// Shared helpers and encodings for the front-panel input conditioner.
package ng_panel_pkg;

   // Bits needed to hold the values 0..value-1 (at least one bit).
   function automatic int clog2(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) w++;
      return w;
   endfunction

   // Per-channel auto-repeat state.
   typedef enum logic {
      RPT_IDLE = 1'b0,
      RPT_HELD = 1'b1
   } rpt_state_e;

endpackage

// File: rtl/ng_panel_ch.sv
// One panel channel: two-flop synchroniser, polarity fix, tick-based
// debounce, registered edge pulses and optional auto-repeat.
module ng_panel_ch
   import ng_panel_pkg::*;
#(
   parameter bit INV       = 1'b1,
   parameter bit RPT_EN    = 1'b0,
   parameter int DB_CNT    = 4,
   parameter int RPT_DELAY = 100,
   parameter int RPT_RATE  = 20
) (
   input  logic CLK,
   input  logic NPURST,
   input  logic tick,
   input  logic sw,
   output logic state,
   output logic rise,
   output logic fall,
   output logic press
);

   localparam int DB_W    = clog2(DB_CNT);
   localparam int RPT_MAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
   localparam int RW      = clog2(RPT_MAX + 1);
   // The counter holds DB_CNT-1 when the next differing tick completes the run.
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CNT - 1);

   logic            sync1_q, sync1_d;
   logic            sync2_q, sync2_d;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic            state_q, state_d;
   logic            rise_q, rise_d;
   logic            fall_q, fall_d;
   logic            press_q, press_d;
   rpt_state_e      rpt_st_q, rpt_st_d;
   logic [RW-1:0]   rpt_cnt_q, rpt_cnt_d;
   logic            level;
   logic            rpt_pulse;

   // Next-state logic: debounce on ticks, then the repeat FSM driven by the edges.
   always_comb begin
      sync1_d   = sw;
      sync2_d   = sync1_q;
      db_cnt_d  = db_cnt_q;
      state_d   = state_q;
      rise_d    = 1'b0;
      fall_d    = 1'b0;
      rpt_st_d  = rpt_st_q;
      rpt_cnt_d = rpt_cnt_q;
      rpt_pulse = 1'b0;
      level     = sync2_q ^ INV;

      if (tick) begin
         if (level != state_q) begin
            if (db_cnt_q == DB_LAST) begin
               state_d  = level;
               db_cnt_d = '0;
               rise_d   = level;
               fall_d   = ~level;
            end else begin
               db_cnt_d = db_cnt_q + 1'b1;
            end
         end else begin
            db_cnt_d = '0;
         end

         if (RPT_EN) begin
            case (rpt_st_q)
               RPT_IDLE: begin
                  if (rise_d) begin
                     rpt_st_d  = RPT_HELD;
                     rpt_cnt_d = RW'(RPT_DELAY);
                  end
               end
               RPT_HELD: begin
                  // A release on the same tick as a repeat suppresses the repeat.
                  if (fall_d) begin
                     rpt_st_d  = RPT_IDLE;
                     rpt_cnt_d = '0;
                  end else if (rpt_cnt_q == RW'(1)) begin
                     rpt_pulse = 1'b1;
                     rpt_cnt_d = RW'(RPT_RATE);
                  end else begin
                     rpt_cnt_d = rpt_cnt_q - 1'b1;
                  end
               end
               default: begin
                  rpt_st_d  = RPT_IDLE;
                  rpt_cnt_d = '0;
               end
            endcase
         end
      end

      press_d = rise_d | rpt_pulse;
   end

   // State registers; synchroniser resets to the released raw level.
   always_ff @(posedge CLK or negedge NPURST) begin
      if (!NPURST) begin
         sync1_q   <= INV;
         sync2_q   <= INV;
         db_cnt_q  <= '0;
         state_q   <= 1'b0;
         rise_q    <= 1'b0;
         fall_q    <= 1'b0;
         press_q   <= 1'b0;
         rpt_st_q  <= RPT_IDLE;
         rpt_cnt_q <= '0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         db_cnt_q  <= db_cnt_d;
         state_q   <= state_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         press_q   <= press_d;
         rpt_st_q  <= rpt_st_d;
         rpt_cnt_q <= rpt_cnt_d;
      end
   end

   assign state = state_q;
   assign rise  = rise_q;
   assign fall  = fall_q;
   assign press = press_q;

endmodule

// File: rtl/ng_panel.sv
// Front-panel input conditioner: shared sample prescaler feeding N_CH
// independent debounce/edge/auto-repeat channels.
module ng_panel
   import ng_panel_pkg::*;
#(
   parameter int              N_CH      = 8,
   parameter int              DIV       = 250000,
   parameter int              DB_CNT    = 4,
   parameter logic [N_CH-1:0] INV_MASK  = '1,
   parameter logic [N_CH-1:0] RPT_MASK  = '0,
   parameter int              RPT_DELAY = 100,
   parameter int              RPT_RATE  = 20
) (
   input  logic            CLK,
   input  logic            NPURST,
   input  logic [N_CH-1:0] sw_in,
   output logic            tick,
   output logic [N_CH-1:0] state,
   output logic [N_CH-1:0] rise,
   output logic [N_CH-1:0] fall,
   output logic [N_CH-1:0] press
);

   if (N_CH < 1 || N_CH > 32) begin : g_bad_nch
      $error("ng_panel: N_CH must be 1..32");
   end
   if (DIV < 1) begin : g_bad_div
      $error("ng_panel: DIV must be >= 1");
   end
   if (DB_CNT < 1 || DB_CNT > 15) begin : g_bad_db
      $error("ng_panel: DB_CNT must be 1..15");
   end
   if (RPT_DELAY < 1 || RPT_RATE < 1) begin : g_bad_rpt
      $error("ng_panel: RPT_DELAY and RPT_RATE must be >= 1");
   end

   localparam int              PS_W    = clog2(DIV);
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);

   logic [PS_W-1:0] ps_cnt_q, ps_cnt_d;
   logic            tick_q, tick_d;

   // Prescaler wrap; tick is registered so it is high exactly while the count is DIV-1.
   always_comb begin
      ps_cnt_d = (ps_cnt_q == PS_LAST) ? '0 : ps_cnt_q + 1'b1;
      tick_d   = (ps_cnt_d == PS_LAST);
   end

   // Prescaler registers.
   always_ff @(posedge CLK or negedge NPURST) begin
      if (!NPURST) begin
         ps_cnt_q <= '0;
         tick_q   <= 1'b0;
      end else begin
         ps_cnt_q <= ps_cnt_d;
         tick_q   <= tick_d;
      end
   end

   assign tick = tick_q;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      ng_panel_ch #(
         .INV       (INV_MASK[i]),
         .RPT_EN    (RPT_MASK[i]),
         .DB_CNT    (DB_CNT),
         .RPT_DELAY (RPT_DELAY),
         .RPT_RATE  (RPT_RATE)
      ) u_ch (
         .CLK    (CLK),
         .NPURST (NPURST),
         .tick   (tick_q),
         .sw     (sw_in[i]),
         .state  (state[i]),
         .rise   (rise[i]),
         .fall   (fall[i]),
         .press  (press[i])
      );
   end

endmodule

// File: tb/tb_ng_panel.sv
// Self-checking bench for ng_panel with a cycle-level behavioural model.
module tb_ng_panel;

   localparam int         N_CH      = 4;
   localparam int         DIV       = 4;
   localparam int         DB_CNT    = 3;
   localparam logic [3:0] INV_MASK  = 4'b1111;
   localparam logic [3:0] RPT_MASK  = 4'b0001;
   localparam int         RPT_DELAY = 5;
   localparam int         RPT_RATE  = 2;

   logic       CLK = 1'b0;
   logic       NPURST;
   logic [3:0] sw_in;
   logic       tick;
   logic [3:0] state, rise, fall, press;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: edges since reset release, raw history, debounced state,
   // run length of differing ticks, and ticks elapsed since the last press-down.
   int         n_edges;
   logic       m_tick;
   logic [3:0] r1, r2;
   logic [3:0] m_state;
   int         streak [4];
   bit         held   [4];
   int         since  [4];
   logic [3:0] e_rise, e_fall, e_press;

   ng_panel #(
      .N_CH      (N_CH),
      .DIV       (DIV),
      .DB_CNT    (DB_CNT),
      .INV_MASK  (INV_MASK),
      .RPT_MASK  (RPT_MASK),
      .RPT_DELAY (RPT_DELAY),
      .RPT_RATE  (RPT_RATE)
   ) dut (
      .CLK    (CLK),
      .NPURST (NPURST),
      .sw_in  (sw_in),
      .tick   (tick),
      .state  (state),
      .rise   (rise),
      .fall   (fall),
      .press  (press)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      n_edges = 0;
      m_tick  = 1'b0;
      r1      = INV_MASK;
      r2      = INV_MASK;
      m_state = '0;
      e_rise  = '0;
      e_fall  = '0;
      e_press = '0;
      for (int i = 0; i < 4; i++) begin
         streak[i] = 0;
         held[i]   = 1'b0;
         since[i]  = 0;
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".tick"},  {3'b000, tick}, {3'b000, m_tick});
      chk({tag, ".state"}, state, m_state);
      chk({tag, ".rise"},  rise,  e_rise);
      chk({tag, ".fall"},  fall,  e_fall);
      chk({tag, ".press"}, press, e_press);
   endtask

   // Advance model and DUT by one clock edge, then compare every output.
   task automatic cycle(input string tag);
      logic lvl;
      logic rpt;
      e_rise  = '0;
      e_fall  = '0;
      e_press = '0;
      if (m_tick) begin
         for (int i = 0; i < 4; i++) begin
            lvl = r2[i] ^ INV_MASK[i];
            rpt = 1'b0;
            if (lvl != m_state[i]) begin
               streak[i]++;
               if (streak[i] == DB_CNT) begin
                  m_state[i] = lvl;
                  streak[i]  = 0;
                  if (lvl) e_rise[i] = 1'b1;
                  else     e_fall[i] = 1'b1;
               end
            end else begin
               streak[i] = 0;
            end
            if (RPT_MASK[i]) begin
               if (e_fall[i]) begin
                  held[i] = 1'b0;
               end else if (e_rise[i]) begin
                  held[i]  = 1'b1;
                  since[i] = 0;
               end else if (held[i]) begin
                  since[i]++;
                  if (since[i] == RPT_DELAY ||
                      (since[i] > RPT_DELAY && (since[i] - RPT_DELAY) % RPT_RATE == 0))
                     rpt = 1'b1;
               end
            end
            e_press[i] = e_rise[i] | rpt;
         end
      end
      r2 = r1;
      r1 = sw_in;
      n_edges++;
      m_tick = ((n_edges % DIV) == DIV - 1);
      @(posedge CLK);
      #1;
      chk_all(tag);
   endtask

   // Asynchronous reset: outputs must clear before any clock edge.
   task automatic do_reset(input string tag);
      NPURST = 1'b0;
      #2;
      chk({tag, ".async_state"}, state, 4'h0);
      chk({tag, ".async_pulses"}, rise | fall | press, 4'h0);
      chk({tag, ".async_tick"}, {3'b000, tick}, 4'h0);
      repeat (2) @(posedge CLK);
      #1;
      model_reset();
      chk_all({tag, ".held"});
      NPURST = 1'b1;
   endtask

   initial begin
      int lat;
      int n_tick;
      NPURST = 1'b0;
      sw_in  = 4'hF;
      model_reset();
      @(posedge CLK);
      #1;

      // Reset with all switches released, then idle.
      do_reset("rst0");
      n_tick = 0;
      for (int c = 0; c < 16; c++) begin
         cycle("idle");
         if (tick) n_tick++;
      end
      chk("idle_tick_count", 4'(n_tick), 4'd4);

      // Channel 1 press and release, with an explicit latency window check.
      sw_in[1] = 1'b0;
      lat = 0;
      while (!state[1] && lat < 20) begin
         cycle("ch1_press");
         lat++;
      end
      chk("ch1_rise_latency_ok", {3'b000, (lat >= 11 && lat <= 14)}, 4'd1);
      repeat (6) cycle("ch1_hold");
      sw_in[1] = 1'b1;
      lat = 0;
      while (state[1] && lat < 20) begin
         cycle("ch1_release");
         lat++;
      end
      chk("ch1_fall_latency_ok", {3'b000, (lat >= 11 && lat <= 14)}, 4'd1);
      repeat (6) cycle("ch1_idle");

      // Channel 2 bounces for only two ticks at a time.
      for (int b = 0; b < 4; b++) begin
         sw_in[2] = 1'b0;
         repeat (8) cycle("ch2_bounce_lo");
         sw_in[2] = 1'b1;
         repeat (8) cycle("ch2_bounce_hi");
      end
      chk("ch2_never_pressed", {3'b000, state[2]}, 4'd0);

      // Channel 0 held for 20 ticks with auto-repeat, then released.
      sw_in[0] = 1'b0;
      repeat (80) cycle("ch0_held");
      sw_in[0] = 1'b1;
      repeat (24) cycle("ch0_release");

      // All channels pressed in the same cycle.
      sw_in = 4'h0;
      lat = 0;
      while (rise == 4'h0 && lat < 20) begin
         cycle("all_press");
         lat++;
      end
      chk("all_rise_together", rise, 4'hF);
      repeat (8) cycle("all_hold");

      // Release all, then reset in the middle of the debounce.
      sw_in = 4'hF;
      repeat (6) cycle("all_release");
      do_reset("rst_mid");
      repeat (20) cycle("after_rst");

      // Randomised stretch with one reset in the middle.
      for (int c = 0; c < 700; c++) begin
         if ($urandom_range(0, 14) == 0) sw_in = 4'($urandom);
         if (c == 350) do_reset("rst_rand");
         cycle("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
